// File: rtl/furv_dmem.sv
// Data-memory responder for the furv core load/store port: word RAM plus a
// two-register MMIO window (GPIO, free-running CYCLE) with programmable load latency.
module furv_dmem #(
  parameter int          ADDR_WIDTH   = 10,
  parameter int          READ_LATENCY = 1,
  parameter              INIT_FILE    = "",
  parameter logic [31:0] MMIO_BASE    = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        read_ack,
  output logic [31:0] gpio,
  output logic        bus_error
);

  localparam int          DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [31:0] CYCLE_ADDR = MMIO_BASE + 32'd4;
  localparam logic [3:0]  LAT        = 4'(READ_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  typedef enum logic [1:0] {TGT_RAM, TGT_GPIO, TGT_CYCLE, TGT_NONE} tgt_t;

  logic [31:0] ram [DEPTH];

  // Elaboration-time preload only; RAM contents are never touched by rst.
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 32'h0;
  end

  state_t                  state;
  logic [3:0]              cnt;
  logic                    mem_q;
  logic [31:0]             cycle;
  tgt_t                    tgt, tgt_q;
  logic [ADDR_WIDTH-1:0]   idx, idx_q;
  logic [31:0]             rd_now, rd_lat;
  logic                    accept;
  logic                    unused_addr;

  assign unused_addr = ^addr[1:0];
  assign idx         = addr[ADDR_WIDTH+1:2];
  assign accept      = mem && !mem_q && (state == S_IDLE);

  always_comb begin
    tgt = TGT_NONE;
    if (addr[31:ADDR_WIDTH+2] == '0)             tgt = TGT_RAM;
    else if (addr[31:2] == MMIO_BASE[31:2])      tgt = TGT_GPIO;
    else if (addr[31:2] == CYCLE_ADDR[31:2])     tgt = TGT_CYCLE;
  end

  // Zero-latency loads read from the live address; delayed loads from the latched one.
  always_comb begin
    rd_now = 32'h0;
    case (tgt)
      TGT_RAM:   rd_now = ram[idx];
      TGT_GPIO:  rd_now = gpio;
      TGT_CYCLE: rd_now = cycle;
      default:   rd_now = 32'h0;
    endcase
  end

  always_comb begin
    rd_lat = 32'h0;
    case (tgt_q)
      TGT_RAM:   rd_lat = ram[idx_q];
      TGT_GPIO:  rd_lat = gpio;
      TGT_CYCLE: rd_lat = cycle;
      default:   rd_lat = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && accept && mem_write && tgt == TGT_RAM) ram[idx] <= data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      mem_q     <= 1'b0;
      cycle     <= 32'h0;
      data_in   <= 32'h0;
      read_ack  <= 1'b0;
      gpio      <= 32'h0;
      bus_error <= 1'b0;
      tgt_q     <= TGT_NONE;
      idx_q     <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      mem_q <= mem;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (mem_write) begin
              if (tgt == TGT_GPIO)      gpio      <= data_out;
              else if (tgt == TGT_NONE) bus_error <= 1'b1;
            end else begin
              tgt_q <= tgt;
              idx_q <= idx;
              if (tgt == TGT_NONE) bus_error <= 1'b1;
              if (LAT == 4'd0) begin
                data_in  <= rd_now;
                read_ack <= 1'b1;
                state    <= S_ACK;
              end else begin
                cnt   <= LAT;
                state <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (!mem) begin
            state <= S_IDLE;
          end else if (cnt == 4'd1) begin
            data_in  <= rd_lat;
            read_ack <= 1'b1;
            state    <= S_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          if (!mem) begin
            read_ack <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_furv_dmem.sv
// Bench for furv_dmem: two instances (latency 0 and 3) driven like the core,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_furv_dmem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        mem [2];
  logic        mem_write [2];
  logic [31:0] addr [2];
  logic [31:0] dout [2];
  logic [31:0] din [2];
  logic [31:0] gpio [2];
  logic        ack [2];
  logic        berr [2];

  furv_dmem #(.READ_LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst[0]), .mem(mem[0]), .mem_write(mem_write[0]), .addr(addr[0]),
    .data_out(dout[0]), .data_in(din[0]), .read_ack(ack[0]), .gpio(gpio[0]), .bus_error(berr[0])
  );

  furv_dmem #(.READ_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst[1]), .mem(mem[1]), .mem_write(mem_write[1]), .addr(addr[1]),
    .data_out(dout[1]), .data_in(din[1]), .read_ack(ack[1]), .gpio(gpio[1]), .bus_error(berr[1])
  );

  int          lat_of [2] = '{0, 3};
  logic [31:0] m_ram [2][1024];
  logic [31:0] m_gpio [2];
  logic [31:0] m_data [2];
  logic        m_ack [2];
  logic        m_berr [2];
  int unsigned n_cyc [2];
  int          ecount = 0;
  bit          chk_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int kind(logic [31:0] a);
    if (a < 32'h0000_1000) return 0;
    if ((a & 32'hFFFF_FFFC) == 32'h8000_0000) return 1;
    if ((a & 32'hFFFF_FFFC) == 32'h8000_0004) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] model_read(int d, logic [31:0] a);
    case (kind(a))
      0: return m_ram[d][int'((a >> 2) & 32'h3FF)];
      1: return m_gpio[d];
      2: return n_cyc[d];
      default: return 32'h0;
    endcase
  endfunction

  // Number of non-reset rising edges since the last reset edge == the CYCLE register value.
  always @(negedge clk) begin
    ecount++;
    for (int d = 0; d < 2; d++) n_cyc[d] = rst[d] ? 0 : n_cyc[d] + 1;
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d_read_ack", d), 32'(ack[d]), 32'(m_ack[d]));
        check($sformatf("d%0d_data_in", d), din[d], m_data[d]);
        check($sformatf("d%0d_gpio", d), gpio[d], m_gpio[d]);
        check($sformatf("d%0d_bus_error", d), 32'(berr[d]), 32'(m_berr[d]));
      end
    end
  end

  task automatic store(int d, logic [31:0] a, logic [31:0] v, int hold);
    @(negedge clk); #1;
    mem[d] = 1'b1; mem_write[d] = 1'b1; addr[d] = a; dout[d] = v;
    @(posedge clk);
    case (kind(a))
      0: m_ram[d][int'((a >> 2) & 32'h3FF)] = v;
      1: m_gpio[d] = v;
      2: ;
      default: m_berr[d] = 1'b1;
    endcase
    // Corrupt data while held: a repeated acceptance would become visible.
    for (int i = 1; i < hold; i++) begin
      @(negedge clk); #1; dout[d] = v ^ 32'h77;
      @(posedge clk);
    end
    @(negedge clk); #1;
    mem[d] = 1'b0; mem_write[d] = 1'b0;
  endtask

  // Called at the acceptance edge; returns data, edges to ack and an ack timestamp.
  task automatic finish_load(int d, logic [31:0] a, output logic [31:0] got,
                             output int e, output int stamp);
    if (kind(a) == 3) m_berr[d] = 1'b1;
    e = 0;
    if (lat_of[d] == 0) begin
      m_ack[d] = 1'b1; m_data[d] = model_read(d, a);
    end
    #2;
    while (ack[d] !== 1'b1 && e < 20) begin
      @(posedge clk);
      e++;
      if (e == lat_of[d]) begin
        m_ack[d] = 1'b1; m_data[d] = model_read(d, a);
      end
      #2;
    end
    got   = din[d];
    stamp = ecount;
    @(negedge clk); #1;
    mem[d] = 1'b0;
    @(posedge clk);
    m_ack[d] = 1'b0;
  endtask

  task automatic load(int d, logic [31:0] a, output logic [31:0] got,
                      output int e, output int stamp);
    @(negedge clk); #1;
    mem[d] = 1'b1; mem_write[d] = 1'b0; addr[d] = a;
    @(posedge clk);
    finish_load(d, a, got, e, stamp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g, g2;
    int e, e2, s, s2;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; mem[d] = 1'b0; mem_write[d] = 1'b0; addr[d] = 32'h0; dout[d] = 32'h0;
      m_gpio[d] = 32'h0; m_data[d] = 32'h0; m_ack[d] = 1'b0; m_berr[d] = 1'b0; n_cyc[d] = 0;
      for (int i = 0; i < 1024; i++) m_ram[d][i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #2;
    check("reset_ack", 32'(ack[1]), 32'h0);
    check("reset_data", din[1], 32'h0);
    @(negedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk_en = 1'b1;

    // Zero latency: data with ack at the acceptance edge, ack gone one edge after mem falls.
    store(0, 32'h40, 32'hDEAD_BEEF, 1);
    load(0, 32'h40, g, e, s);
    check("lat0_data", g, 32'hDEAD_BEEF);
    check("lat0_edges", 32'(e), 32'h0);
    #2;
    check("lat0_ack_fall", 32'(ack[0]), 32'h0);
    store(0, 32'h0020_0000, 32'h5, 1);
    check("lat0_unmapped_store_berr", 32'(berr[0]), 32'h1);

    // Latency 3.
    store(1, 32'h0, 32'h0000_0013, 1);
    load(1, 32'h0, g, e, s);
    check("lat3_data", g, 32'h0000_0013);
    check("lat3_edges", 32'(e), 32'h3);

    // Held store is performed once; second store overwrites.
    store(1, 32'h8, 32'h1, 3);
    load(1, 32'h8, g, e, s);
    check("held_store_once", g, 32'h1);
    store(1, 32'h8, 32'h2, 1);
    load(1, 32'h8, g, e, s);
    check("second_store", g, 32'h2);

    // MMIO window.
    store(1, 32'h8000_0000, 32'hA5, 1);
    check("gpio_literal", gpio[1], 32'hA5);
    store(1, 32'h8000_0004, 32'h0012_3456, 1);
    check("cycle_store_no_berr", 32'(berr[1]), 32'h0);
    load(1, 32'h8000_0004, g, e, s);
    load(1, 32'h8000_0004, g2, e2, s2);
    check("cycle_delta", g2 - g, 32'(s2 - s));
    load(1, 32'h8000_0000, g, e, s);
    check("gpio_readback", g, 32'hA5);

    // Unmapped load: zero data, normal latency, sticky error.
    load(1, 32'h0010_0000, g, e, s);
    check("unmapped_data", g, 32'h0);
    check("unmapped_edges", 32'(e), 32'h3);
    check("unmapped_berr", 32'(berr[1]), 32'h1);
    load(1, 32'h8, g, e, s);
    check("berr_sticky", 32'(berr[1]), 32'h1);

    // Reset while waiting with mem held: aborts, then restarts as a new request.
    @(negedge clk); #1;
    mem[1] = 1'b1; mem_write[1] = 1'b0; addr[1] = 32'h0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk);
    m_ack[1] = 1'b0; m_data[1] = 32'h0; m_gpio[1] = 32'h0; m_berr[1] = 1'b0;
    #2;
    check("rst_ack", 32'(ack[1]), 32'h0);
    check("rst_gpio", gpio[1], 32'h0);
    check("rst_berr", 32'(berr[1]), 32'h0);
    @(negedge clk); #1;
    rst[1] = 1'b0;
    @(posedge clk);
    finish_load(1, 32'h0, g, e, s);
    check("restart_data", g, 32'h0000_0013);
    check("restart_edges", 32'(e), 32'h3);

    repeat (3) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
